// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 10110 detector scheduler.
// Holds the FSM state enum, default sizes and the target pattern.
package seq_det_pkg;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_WORD_W = 8;

    localparam logic [4:0] PATTERN = 5'b10110;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/seq_det_sched_if.sv
// Bundle between the requesters, the scheduler and the serial detector.
// master = requester/detector side, slave = scheduler side.
interface seq_det_sched_if
    import seq_det_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W + 1)
);

    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] data;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [CNT_W-1:0]       hit_cnt;
    logic                   det_rst;
    logic                   det_bit;
    logic                   det_out;

    modport master (
        output req,
        output data,
        output det_out,
        input  gnt,
        input  busy,
        input  done,
        input  done_id,
        input  hit_cnt,
        input  det_rst,
        input  det_bit
    );

    modport slave (
        input  req,
        input  data,
        input  det_out,
        output gnt,
        output busy,
        output done,
        output done_id,
        output hit_cnt,
        output det_rst,
        output det_bit
    );

endinterface

// File: rtl/det_10110.sv
// Serial Moore detector for 10110 with overlap.
// det reflects the bit consumed on the previous clock edge.
module det_10110 (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic det
);

    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4,
        S5
    } det_state_e;

    det_state_e state_q, state_d;

    // next state: longest pattern prefix that is a suffix of the input
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S0:      state_d = din ? S1 : S0;
            S1:      state_d = din ? S1 : S2;
            S2:      state_d = din ? S3 : S0;
            S3:      state_d = din ? S4 : S2;
            S4:      state_d = din ? S1 : S5;
            S5:      state_d = din ? S3 : S0;
            default: state_d = S0;
        endcase
    end

    // state register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign det = (state_q == S5);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request after the last winner.
// The pointer only moves when a grant is actually issued.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] last_q, last_d;
    logic          found;
    int            j;

    // scan from last+1 upward, wrapping, and take the first request
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        last_d  = last_q;
        found   = 1'b0;
        j       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last_q) + k) % NREQ;
            if (!found && en && req[IW'(j)]) begin
                found         = 1'b1;
                gnt[IW'(j)]   = 1'b1;
                gnt_idx       = IW'(j);
            end
        end
        if (found) begin
            last_d = gnt_idx;
        end
    end

    // pointer starts at NREQ-1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one serial 10110 detector among NREQ word producers.
// Grant, clear detector, shift word MSB-first, count hits, report.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input logic            clk,
    input logic            rst,
    seq_det_sched_if.slave bus
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int IDX_W = $clog2(WORD_W);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;

    logic               arb_en;
    logic [NREQ-1:0]    arb_gnt;
    logic [ID_W-1:0]    arb_idx;

    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (arb_en),
        .req     (bus.req),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // sequencing: capture word, clear detector, shift, drain, report
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        id_d      = id_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        hit_cnt_d = hit_cnt_q;
        done_id_d = done_id_q;
        unique case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_gnt[i]) begin
                            word_d = bus.data[i*WORD_W +: WORD_W];
                        end
                    end
                    id_d    = arb_idx;
                    state_d = CLR;
                end
            end
            CLR: begin
                idx_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                word_d = word_q << 1;
                if ((idx_q != '0) && bus.det_out && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                hit_cnt_d = cnt_q;
                if (bus.det_out && (cnt_q != CNT_MAX)) begin
                    hit_cnt_d = cnt_q + 1'b1;
                end
                done_id_d = id_q;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            id_q      <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            hit_cnt_q <= '0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            hit_cnt_q <= hit_cnt_d;
            done_id_q <= done_id_d;
        end
    end

    // outputs are forced quiet while reset is asserted
    assign bus.gnt     = arb_gnt;
    assign bus.busy    = !rst && (state_q != IDLE);
    assign bus.done    = !rst && (state_q == DONE);
    assign bus.det_rst = rst || (state_q == CLR);
    assign bus.det_bit = !rst && (state_q == SHIFT) && word_q[WORD_W-1];
    assign bus.hit_cnt = rst ? '0 : hit_cnt_q;
    assign bus.done_id = rst ? '0 : done_id_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: 4x8-bit and 2x16-bit instances with detectors.
// Directed tables, hand sequences and a random run against a cycle model.
module tb_seq_det_sched;
    import seq_det_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_det_sched_if #(.NREQ(4), .WORD_W(8))  b8 ();
    seq_det_sched_if #(.NREQ(2), .WORD_W(16)) b16 ();

    seq_det_sched #(.NREQ(4), .WORD_W(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    seq_det_sched #(.NREQ(2), .WORD_W(16)) u16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    det_10110 d8 (
        .clk (clk),
        .rst (b8.det_rst),
        .din (b8.det_bit),
        .det (b8.det_out)
    );

    det_10110 d16 (
        .clk (clk),
        .rst (b16.det_rst),
        .din (b16.det_bit),
        .det (b16.det_out)
    );

    typedef struct {
        logic [3:0] req;
        logic [7:0] word;
        int         id;
        int         cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic        nxt_rst;
    logic [3:0]  nxt_req8;
    logic [31:0] nxt_data8;
    logic [1:0]  nxt_req16;
    logic [31:0] nxt_data16;

    int         mcyc = 0;
    int         m_last;
    int         m_gc;
    int         m_free;
    int         m_id;
    int         m_cnt;
    bit         m_pend;
    logic [7:0] m_word;
    int         m_hold_cnt;
    int         m_hold_id;
    logic       drain_det;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // hits over an MSB-first bit stream, overlapping windows allowed
    function automatic int hits(input logic [15:0] w, input int width);
        int c = 0;
        logic [4:0] win;
        for (int p = 4; p < width; p++) begin
            for (int k = 0; k < 5; k++) begin
                win[4-k] = w[width-1-(p-4+k)];
            end
            if (win == PATTERN) c++;
        end
        return c;
    endfunction

    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // cycle-level model of the 4x8 instance, checked every cycle
    task automatic mon();
        int e;
        int d;
        logic [3:0] eg;
        mcyc++;
        if (rst) begin
            m_last     = 3;
            m_pend     = 1'b0;
            m_gc       = -100;
            m_free     = mcyc + 1;
            m_hold_cnt = 0;
            m_hold_id  = 0;
            chk("rst_gnt", b8.gnt, 0);
            chk("rst_busy", b8.busy, 0);
            chk("rst_done", b8.done, 0);
            chk("rst_det_bit", b8.det_bit, 0);
            chk("rst_det_rst", b8.det_rst, 1);
            chk("rst_hit_cnt", b8.hit_cnt, 0);
            chk("rst_done_id", b8.done_id, 0);
        end else begin
            e = -1;
            if (mcyc >= m_free && b8.req != 4'b0) begin
                e = rr_pick(m_last, b8.req);
            end
            eg = (e < 0) ? 4'b0 : 4'(1 << e);
            chk("m_gnt", b8.gnt, eg);
            if (e >= 0) begin
                m_last = e;
                m_gc   = mcyc;
                m_pend = 1'b1;
                m_id   = e;
                m_word = 8'(b8.data >> (e * 8));
                m_cnt  = hits({8'h0, m_word}, 8);
                m_free = mcyc + 12;
            end
            d = mcyc - m_gc;
            chk("m_busy", b8.busy, (m_pend && d >= 1 && d <= 11) ? 1 : 0);
            chk("m_det_rst", b8.det_rst, (m_pend && d == 1) ? 1 : 0);
            chk("m_det_bit", b8.det_bit,
                (m_pend && d >= 2 && d <= 9) ? 32'(m_word[9-d]) : 0);
            chk("m_done", b8.done, (m_pend && d == 11) ? 1 : 0);
            if (m_pend && d == 11) begin
                m_hold_cnt = m_cnt;
                m_hold_id  = m_id;
                m_pend     = 1'b0;
            end
            chk("m_hit_cnt", b8.hit_cnt, m_hold_cnt);
            chk("m_done_id", b8.done_id, m_hold_id);
        end
    endtask

    // apply next inputs just after the rising edge, sample at falling edge
    task automatic step();
        @(posedge clk);
        #1;
        rst      = nxt_rst;
        b8.req   = nxt_req8;
        b8.data  = nxt_data8;
        b16.req  = nxt_req16;
        b16.data = nxt_data16;
        @(negedge clk);
        mon();
    endtask

    task automatic wait_gnt8();
        int n = 0;
        while (b8.gnt == 4'b0 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic run_txn8(input logic [3:0] r, input logic [7:0] w,
                            input int id, input int cnt, input string nm);
        logic [7:0] bits;
        nxt_req8  = r;
        nxt_data8 = 32'h0;
        nxt_data8[id*8 +: 8] = w;
        step();
        wait_gnt8();
        chk({nm, "_gnt"}, b8.gnt, 32'(1 << id));
        nxt_req8 = 4'b0;
        step();
        chk({nm, "_clr"}, b8.det_rst, 1);
        for (int j = 0; j < 8; j++) begin
            step();
            bits[7-j] = b8.det_bit;
        end
        chk({nm, "_bits"}, bits, w);
        step();
        drain_det = b8.det_out;
        chk({nm, "_drain_done"}, b8.done, 0);
        step();
        chk({nm, "_done"}, b8.done, 1);
        chk({nm, "_hit_cnt"}, b8.hit_cnt, cnt);
        chk({nm, "_done_id"}, b8.done_id, id);
        step();
        chk({nm, "_idle"}, b8.busy, 0);
    endtask

    task automatic run_txn16(input logic [1:0] r, input logic [15:0] w,
                             input int id, input int cnt, input string nm);
        int n;
        int t;
        nxt_req16  = r;
        nxt_data16 = 32'h0;
        nxt_data16[id*16 +: 16] = w;
        step();
        n = 0;
        while (b16.gnt == 2'b0 && n < 40) begin
            step();
            n++;
        end
        chk({nm, "_gnt"}, b16.gnt, 32'(1 << id));
        t = mcyc;
        nxt_req16 = 2'b0;
        step();
        n = 0;
        while (!b16.done && n < 40) begin
            step();
            n++;
        end
        chk({nm, "_lat"}, mcyc - t, 19);
        chk({nm, "_hit_cnt"}, b16.hit_cnt, cnt);
        chk({nm, "_model"}, b16.hit_cnt, hits(w, 16));
        chk({nm, "_done_id"}, b16.done_id, id);
        step();
    endtask

    initial begin
        vec_t tbl[7];
        int   prev;
        int   n;
        bit   saw_done;

        tbl[0] = '{4'b0001, 8'hB0, 0, 1};
        tbl[1] = '{4'b0100, 8'hFF, 2, 0};
        tbl[2] = '{4'b0001, 8'b00010110, 0, 1};
        tbl[3] = '{4'b1000, 8'b10110110, 3, 2};
        tbl[4] = '{4'b0010, 8'h00, 1, 0};
        tbl[5] = '{4'b1010, 8'b01011010, 3, 1};
        tbl[6] = '{4'b1111, 8'b10110101, 0, 1};

        rst      = 1'b1;
        b8.req   = '0;
        b8.data  = '0;
        b16.req  = '0;
        b16.data = '0;
        nxt_rst    = 1'b1;
        nxt_req8   = '0;
        nxt_data8  = '0;
        nxt_req16  = '0;
        nxt_data16 = '0;
        m_last = 3;
        m_pend = 1'b0;
        m_gc   = -100;
        m_free = 0;
        m_hold_cnt = 0;
        m_hold_id  = 0;
        drain_det  = 1'b0;

        repeat (3) step();
        nxt_rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_txn8(tbl[i].req, tbl[i].word, tbl[i].id, tbl[i].cnt,
                     $sformatf("vec%0d", i));
            if (i == 2) chk("last_bit_drain_det", drain_det, 1);
        end

        // fairness: all four request, each drops after its own grant
        nxt_rst = 1'b1;
        step();
        nxt_rst   = 1'b0;
        nxt_req8  = 4'b1111;
        nxt_data8 = $urandom();
        prev = 0;
        step();
        for (int k = 0; k < 4; k++) begin
            wait_gnt8();
            chk($sformatf("rr%0d_gnt", k), b8.gnt, 32'(1 << k));
            if (k > 0) chk($sformatf("rr%0d_gap", k), mcyc - prev, 12);
            prev = mcyc;
            nxt_req8[k] = 1'b0;
            if (k == 3) nxt_req8 = 4'b1001;
            step();
        end
        wait_gnt8();
        chk("rr_wrap_gnt", b8.gnt, 4'b0001);
        chk("rr_wrap_gap", mcyc - prev, 12);
        nxt_req8 = 4'b1000;
        step();
        wait_gnt8();
        chk("rr_after_gnt", b8.gnt, 4'b1000);
        nxt_req8 = 4'b0;
        repeat (13) step();

        // reset in the middle of SHIFT
        nxt_req8  = 4'b0001;
        nxt_data8 = 32'h0000_00B0;
        step();
        wait_gnt8();
        nxt_req8 = 4'b0;
        repeat (4) step();
        chk("pre_rst_det_bit", b8.det_bit, 1);
        nxt_rst = 1'b1;
        step();
        chk("mid_rst_det_rst", b8.det_rst, 1);
        chk("mid_rst_busy", b8.busy, 0);
        chk("mid_rst_done", b8.done, 0);
        chk("mid_rst_det_bit", b8.det_bit, 0);
        nxt_rst = 1'b0;
        saw_done = 1'b0;
        for (int j = 0; j < 14; j++) begin
            step();
            if (b8.done) saw_done = 1'b1;
        end
        chk("mid_rst_no_done", saw_done, 0);
        run_txn8(4'b0011, 8'hB6, 0, 2, "post_rst");

        // 16-bit instance
        run_txn16(2'b01, 16'hB580, 0, 2, "w16a");
        run_txn16(2'b10, 16'hB6B6, 1, 4, "w16b");

        // random traffic with occasional resets against the model
        for (int it = 0; it < 1500; it++) begin
            nxt_req8  = 4'($urandom());
            nxt_data8 = $urandom();
            nxt_rst   = ($urandom_range(0, 149) == 0);
            step();
        end
        nxt_rst  = 1'b0;
        nxt_req8 = 4'b0;
        n = 0;
        while (n < 15) begin
            step();
            n++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
